// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the mux select scanner
//
// Purpose : FSM state encoding and sizing constants used by mux_scan_ctrl
//           and its dwell counter.
// Contents: scan_state_t (IDLE, SCAN, DONE), NUM_INPUTS, SEL_W, CNT_W,
//           last_sel() helper.
package mux_scan_pkg;

  // Number of mux data inputs walked by one scan.
  localparam int NUM_INPUTS = 16;

  // Width of the select code driven onto S1..S4.
  localparam int SEL_W = 4;

  // Width of the dwell counter; wide enough for the largest legal DWELL (255).
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Select code held during the final dwell of a scan.
  function automatic logic [SEL_W-1:0] last_sel();
    return SEL_W'(NUM_INPUTS - 1);
  endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// rtl/mux_scan_dwell_cnt.sv - per-code dwell counter with enable, clear and terminal tick
//
// Purpose : Counts clock cycles while a select code is held and raises tick
//           on the last cycle of each dwell (count == DWELL-1). The count
//           wraps to 0 on that cycle so consecutive dwells run back to back.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           en    - advance the count this cycle
//           clr   - force the count to 0 (wins over en)
//           tick  - high while the count equals DWELL-1
//           count - current count value
module mux_scan_dwell_cnt
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (tick) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - walks a 16:1 mux through all select codes and captures its output
//
// Purpose : On start, drives select codes 0..15 onto {S1,S2,S3,S4}, holding
//           each for DWELL cycles, samples mux_o on the last cycle of each
//           dwell into a shadow register, then publishes the 16 samples as
//           word with a one-cycle done pulse.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           start  - scan request, only honoured in IDLE
//           mux_o  - mux output fed back from the mux
//           S1..S4 - select code, S1 is the MSB
//           busy   - high while scanning and in the done cycle
//           done   - one-cycle pulse when word updates
//           word   - captured word, bit k sampled while select code is k
//           parity - XOR of word (only when MUX_SCAN_PARITY_EN is defined)
// Config  : MUX_SCAN_PARITY_EN adds the registered parity output.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mux_o,
  output logic                  S1,
  output logic                  S2,
  output logic                  S3,
  output logic                  S4,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_INPUTS-1:0] word
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                  parity
`endif
);

  scan_state_t           state;
  logic [SEL_W-1:0]      sel;
  logic [NUM_INPUTS-1:0] shadow;
  logic [NUM_INPUTS-1:0] shadow_nxt;
  logic                  tick;
  logic [CNT_W-1:0]      dwell_count;
  logic                  cnt_en;
  logic                  cnt_clr;

  // The counter only runs in SCAN; every other state holds it at 0 so the
  // first dwell of the next scan starts from a clean count.
  assign cnt_en  = (state == SCAN);
  assign cnt_clr = (state != SCAN);

  mux_scan_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .tick  (tick),
    .count (dwell_count)
  );

  // Shadow with the current sample merged in. The last sample of a scan is
  // taken on the same edge that loads word, so word is fed from this merged
  // value rather than from the shadow register itself.
  always_comb begin
    shadow_nxt      = shadow;
    shadow_nxt[sel] = mux_o;
  end

  assign {S1, S2, S3, S4} = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= '0;
      shadow <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      word   <= '0;
`ifdef MUX_SCAN_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sel  <= '0;
          busy <= 1'b0;
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end

        SCAN: begin
          if (tick) begin
            shadow <= shadow_nxt;
            if (sel == last_sel()) begin
              // Word and done are registered here so both are visible in
              // the single DONE cycle.
              state <= DONE;
              sel   <= '0;
              done  <= 1'b1;
              word  <= shadow_nxt;
`ifdef MUX_SCAN_PARITY_EN
              parity <= ^shadow_nxt;
`endif
            end else begin
              sel <= sel + 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          sel   <= '0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          sel   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl with a behavioural 16:1 mux
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start_r;
  int   cur;
  logic [15:0] i_pat;

  int total = 0;
  int bad   = 0;
  logic [15:0] q[$];

  // Instance A: DWELL = 4
  logic start_a, s1_a, s2_a, s3_a, s4_a, busy_a, done_a, mux_o_a;
  logic [15:0] word_a;
  // Instance B: DWELL = 2
  logic start_b, s1_b, s2_b, s3_b, s4_b, busy_b, done_b, mux_o_b;
  logic [15:0] word_b;
`ifdef MUX_SCAN_PARITY_EN
  logic parity_a, parity_b, parity_v;
`endif

  logic [3:0]  sel_a, sel_b, sel_v;
  logic        busy_v, done_v;
  logic [15:0] word_v;

  always #5 clk = ~clk;

  assign sel_a   = {s1_a, s2_a, s3_a, s4_a};
  assign sel_b   = {s1_b, s2_b, s3_b, s4_b};
  assign mux_o_a = i_pat[sel_a];
  assign mux_o_b = i_pat[sel_b];
  assign start_a = start_r && (cur == 0);
  assign start_b = start_r && (cur == 1);
  assign sel_v   = (cur == 0) ? sel_a  : sel_b;
  assign busy_v  = (cur == 0) ? busy_a : busy_b;
  assign done_v  = (cur == 0) ? done_a : done_b;
  assign word_v  = (cur == 0) ? word_a : word_b;
`ifdef MUX_SCAN_PARITY_EN
  assign parity_v = (cur == 0) ? parity_a : parity_b;
`endif

  mux_scan_ctrl #(.DWELL(4)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_a),
    .mux_o  (mux_o_a),
    .S1     (s1_a),
    .S2     (s2_a),
    .S3     (s3_a),
    .S4     (s4_a),
    .busy   (busy_a),
    .done   (done_a),
    .word   (word_a)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .parity (parity_a)
`endif
  );

  mux_scan_ctrl #(.DWELL(2)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_b),
    .mux_o  (mux_o_b),
    .S1     (s1_b),
    .S2     (s2_b),
    .S3     (s3_b),
    .S4     (s4_b),
    .busy   (busy_b),
    .done   (done_b),
    .word   (word_b)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .parity (parity_b)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full scan on the current instance. The expected word is queued when
  // start is driven and popped when done is seen.
  task automatic scan(input int d, input logic [15:0] pat, input logic [15:0] exp_w,
                      input bit hold, input logic [15:0] prev,
                      input int chg_c, input logic [15:0] chg_pat);
    int last;
    int ndone;
    bit sel_ok, busy_ok, done_ok, hold_ok;
    logic [15:0] e;
    last = 16 * d + 2;
    ndone = 0;
    sel_ok = 1; busy_ok = 1; done_ok = 1; hold_ok = 1;
    i_pat = pat;
    q.push_back(exp_w);
    start_r = 1'b1;
    step();
    start_r = hold;
    for (int c = 1; c <= last; c++) begin
      if (c == chg_c) i_pat = chg_pat;
      if (c <= 16 * d) begin
        if (sel_v !== 4'((c - 1) / d)) sel_ok = 0;
      end else if (sel_v !== 4'd0) begin
        sel_ok = 0;
      end
      if (busy_v !== (c < last)) busy_ok = 0;
      if (done_v !== (c == 16 * d + 1)) done_ok = 0;
      if (c <= 16 * d && word_v !== prev) hold_ok = 0;
      if (done_v === 1'b1) begin
        ndone++;
        chk("sb_depth", q.size(), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("word", word_v, e);
`ifdef MUX_SCAN_PARITY_EN
          chk("parity", parity_v, ^e);
`endif
        end
      end
      if (c == last) start_r = 1'b0;
      if (c < last) step();
    end
    chk("sel_sequence", sel_ok, 1);
    chk("busy_window", busy_ok, 1);
    chk("done_timing", done_ok, 1);
    chk("word_hold", hold_ok, 1);
    chk("done_count", ndone, 1);
    step();
    chk("idle_after", busy_v, 0);
  endtask

  initial begin
    bit idle_ok;
    rst_n   = 1'b0;
    start_r = 1'b0;
    cur     = 0;
    i_pat   = 16'h0000;
    step();
    step();
    rst_n = 1'b1;

    idle_ok = 1;
    for (int c = 0; c < 20; c++) begin
      if ({sel_a, busy_a, done_a, word_a, sel_b, busy_b, done_b, word_b} !== '0) idle_ok = 0;
`ifdef MUX_SCAN_PARITY_EN
      if ({parity_a, parity_b} !== 2'b00) idle_ok = 0;
`endif
      step();
    end
    chk("reset_idle_outputs", idle_ok, 1);

    cur = 0;
    scan(4, 16'hAAAA, 16'hAAAA, 0, 16'h0000, 0, 16'h0000);

    cur = 1;
    scan(2, 16'h0001, 16'h0001, 0, 16'h0000, 0, 16'h0000);

    cur = 0;
    scan(4, 16'h5555, 16'h5555, 1, 16'hAAAA, 0, 16'h0000);

    i_pat   = 16'h3C3C;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    repeat (29) step();
    chk("pre_reset_busy", busy_v, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_busy", busy_v, 0);
    chk("reset_word", word_v, 16'h0000);
    chk("reset_sel", sel_v, 4'd0);
    chk("reset_done", done_v, 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", busy_v, 0);

    scan(4, 16'h3C3C, 16'h3C3C, 0, 16'h0000, 0, 16'h0000);

    scan(4, 16'h0000, 16'hFF00, 0, 16'h3C3C, 33, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
